// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam int MAX_WORDS_DEFAULT = 1024;
  localparam int IMEM_BYTE_ADDR_W  = 32;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler with a registered word_valid pulse.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  count
);

  // Bytes enter at the top, so after four shifts the first byte sits in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
      count      <= '0;
    end else begin
      word_valid <= shift && (count == 2'd3);
      if (clear) begin
        word  <= '0;
        count <= '0;
      end else if (shift) begin
        word  <= {byte_in, word[31:8]};
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes instruction memory and releases the core
// from reset only after a complete, checksum-valid image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  loader_state_t state, next_state;

  logic        hs;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_n;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic [1:0]  byte_cnt;
  logic        last_byte_of_word;

  assign hs                = rx_valid && rx_ready;
  assign len_n             = {rx_data, len_lo};
  assign last_byte_of_word = (byte_cnt == 2'd3);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (hs && (state == LEN_HI)),
    .shift      (hs && (state == DATA)),
    .byte_in    (rx_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .count      (byte_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LEN_LO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LEN_LO: if (hs) next_state = LEN_HI;
      LEN_HI: if (hs) next_state = ((len_n == 16'd0) || (len_n > MAX_N)) ? ERR : DATA;
      DATA:   if (hs && last_byte_of_word && (word_idx == len - 16'd1)) next_state = CHECK;
      CHECK:  if (hs) next_state = (rx_data == csum) ? DONE : ERR;
      default: next_state = state;
    endcase
  end

  // Status outputs follow next_state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len_lo    <= '0;
      len       <= '0;
      word_idx  <= '0;
      csum      <= '0;
      imem_addr <= '0;
    end else begin
      rx_ready  <= (next_state != DONE) && (next_state != ERR);
      cpu_rst_n <= (next_state == DONE);
      done      <= (next_state == DONE);
      error     <= (next_state == ERR);
      if (hs) begin
        case (state)
          LEN_LO: len_lo <= rx_data;
          LEN_HI: begin
            len      <= len_n;
            word_idx <= '0;
            csum     <= '0;
          end
          DATA: begin
            csum <= csum ^ rx_data;
            if (last_byte_of_word) begin
              imem_addr <= IMEM_BYTE_ADDR_W'({word_idx, 2'b00});
              word_idx  <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
